// File: rtl/oem8_batch_loader_pkg.sv
// oem_pkg: shared widths, pad value, loader state encoding and lane offset helper
package oem_pkg;
  localparam int OEM_DW = 6;
  localparam int OEM_N = 8;
  localparam int OEM_CNT_W = 4;
  localparam logic [OEM_DW-1:0] OEM_PAD = 6'h3F;
  typedef enum logic {FILL, HOLD} state_t;
  function automatic int lane(input int i);
    return OEM_DW * i;
  endfunction
endpackage

// File: rtl/oem8_batch_loader_if.sv
// oem8_batch_loader_if: serial key input and parallel batch output of the loader
interface oem8_batch_loader_if;
  import oem_pkg::*;
  logic                      s_valid;
  logic                      s_ready;
  logic [OEM_DW-1:0]         s_data;
  logic                      s_last;
  logic                      m_valid;
  logic                      m_ready;
  logic [OEM_N*OEM_DW-1:0]   m_data;
  logic [OEM_CNT_W-1:0]      m_count;
  modport slave (input s_valid, s_data, s_last, m_ready, output s_ready, m_valid, m_data, m_count);
  modport master (output s_valid, s_data, s_last, m_ready, input s_ready, m_valid, m_data, m_count);
endinterface

// File: rtl/oem8_out_slot.sv
// oem8_out_slot: registered batch holding slot; contents only change when free
module oem8_out_slot
  import oem_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic [OEM_N*OEM_DW-1:0] data_i,
  input  logic [OEM_CNT_W-1:0]    count_i,
  input  logic                    ready_i,
  output logic                    free_o,
  output logic                    valid_o,
  output logic [OEM_N*OEM_DW-1:0] data_o,
  output logic [OEM_CNT_W-1:0]    count_o
);
  logic                    valid_q;
  logic [OEM_N*OEM_DW-1:0] data_q;
  logic [OEM_CNT_W-1:0]    count_q;
  assign free_o = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o = data_q;
  assign count_o = count_q;
  // load replaces the batch only when the slot is empty or being consumed; consume alone clears valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q <= {OEM_N{OEM_PAD}};
      count_q <= '0;
    end else if (load_i && free_o) begin
      valid_q <= 1'b1;
      data_q <= data_i;
      count_q <= count_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/oem8_batch_loader.sv
// oem8_batch_loader: packs a serial key stream into padded 8-key batches for the merge sorter
module oem8_batch_loader
  import oem_pkg::*;
(
  input logic clk,
  input logic rst_n,
  oem8_batch_loader_if.slave bus
);
  state_t                             state_q, state_d;
  logic [OEM_CNT_W-1:0]               cnt_q, cnt_d, cnt_n, cnt_ld;
  logic [OEM_N-1:0][OEM_DW-1:0]       fill_q, fill_d, fill_w;
  logic [OEM_N*OEM_DW-1:0]            ld_data;
  logic                               accept, done, free, xfer;
  assign bus.s_ready = (state_q == FILL);
  // fill buffer, count and HOLD state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q <= '0;
      fill_q <= {OEM_N{OEM_PAD}};
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fill_q <= fill_d;
    end
  end
  // accept/complete decode, padded batch word and next state; HOLD keeps the finished count frozen
  always_comb begin
    accept = bus.s_valid && state_q == FILL;
    cnt_n = cnt_q + OEM_CNT_W'(1);
    done = accept && (cnt_q == OEM_CNT_W'(OEM_N - 1) || bus.s_last);
    fill_w = fill_q;
    if (accept) fill_w[cnt_q[2:0]] = bus.s_data;
    cnt_ld = (state_q == HOLD) ? cnt_q : cnt_n;
    xfer = free && (done || state_q == HOLD);
    ld_data = '0;
    for (int i = 0; i < OEM_N; i++)
      ld_data[lane(i) +: OEM_DW] = (OEM_CNT_W'(i) < cnt_ld) ? fill_w[i] : OEM_PAD;
    state_d = xfer ? FILL : done ? HOLD : state_q;
    cnt_d = xfer ? '0 : accept ? cnt_n : cnt_q;
    fill_d = xfer ? {OEM_N{OEM_PAD}} : fill_w;
  end
  oem8_out_slot u_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (xfer),
    .data_i  (ld_data),
    .count_i (cnt_ld),
    .ready_i (bus.m_ready),
    .free_o  (free),
    .valid_o (bus.m_valid),
    .data_o  (bus.m_data),
    .count_o (bus.m_count)
  );
endmodule

// File: tb/tb_oem8_batch_loader.sv
// tb_oem8_batch_loader: directed and random stimulus against a batch-queue reference model
module tb_oem8_batch_loader;
  typedef struct {logic [47:0] d; logic [3:0] c;} batch_t;
  localparam logic [47:0] ALLPAD = {8{6'h3F}};
  logic clk, rst_n;
  int checks, errors;
  batch_t exp_q[$];
  logic [5:0] cur[$];
  oem8_batch_loader_if bus();
  oem8_batch_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [47:0] pack(input logic [5:0] k[$]);
    logic [47:0] w;
    w = ALLPAD;
    for (int i = 0; i < k.size(); i++) w[6*i +: 6] = k[i];
    return w;
  endfunction
  task automatic step(input logic v, input logic [5:0] d, input logic l, input logic r);
    logic acc, cons;
    bus.s_valid = v;
    bus.s_data = d;
    bus.s_last = l;
    bus.m_ready = r;
    check("s_ready", bus.s_ready, exp_q.size() < 2);
    check("m_valid", bus.m_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("m_data", bus.m_data, exp_q[0].d);
      check("m_count", bus.m_count, exp_q[0].c);
    end
    acc = v && exp_q.size() < 2;
    cons = r && exp_q.size() > 0;
    if (cons) void'(exp_q.pop_front());
    if (acc) begin
      cur.push_back(d);
      if (cur.size() == 8 || l) begin
        exp_q.push_back('{pack(cur), 4'(cur.size())});
        cur.delete();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst m_valid", bus.m_valid, 0);
    check("rst m_count", bus.m_count, 0);
    check("rst m_data", bus.m_data, ALLPAD);
    exp_q.delete();
    cur.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst s_ready", bus.s_ready, 1);
  endtask
  initial begin
    logic [5:0] ka[8];
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.m_ready = 1'b0;
    @(negedge clk);
    do_reset();
    ka = '{6'd5, 6'd3, 6'd60, 6'd0, 6'd17, 6'd63, 6'd9, 6'd1};
    for (int i = 0; i < 8; i++) step(1, ka[i], 0, 1);
    check("full lanes", bus.m_data, {6'd1, 6'd9, 6'd63, 6'd17, 6'd0, 6'd60, 6'd3, 6'd5});
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    step(1, 12, 0, 1);
    step(1, 7, 0, 1);
    step(1, 40, 1, 1);
    check("short lanes", bus.m_data, {6'd63, 6'd63, 6'd63, 6'd63, 6'd63, 6'd40, 6'd7, 6'd12});
    check("short count", bus.m_count, 3);
    step(0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 6'(i + 20), 0, 0);
    step(1, 50, 0, 0);
    step(1, 50, 0, 0);
    step(1, 50, 0, 1);
    step(1, 50, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 6'(i), 0, 0);
    for (int i = 0; i < 7; i++) step(1, 6'(30 + i), 0, 0);
    step(1, 37, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) step(1, 6'(40 + i), 0, 0);
    for (int i = 0; i < 5; i++) step(1, 6'(i + 1), 0, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 6'(10 + i), 0, 1);
    step(0, 0, 0, 1);
    step(1, 0, 1, 1);
    check("single lanes", bus.m_data, {{7{6'd63}}, 6'd0});
    check("single count", bus.m_count, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 3) != 0), 6'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0));
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
